ps2_key_decoder: RTL and testbench

Receives PS/2 keyboard frames (scan code set 2) on the raw ps2_clk/ps2_data pins and drives the 4-bit one-hot-per-key `key` bus consumed by the car controller. It tracks make and break codes for the four extended arrow keys and holds the current pressed-key mask. It sits between the board PS/2 connector and the game logic, in the pclk domain.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_key_decoder_if.sv | 13 +
 rtl/ps2_rx.sv | 120 ++++++++++++
 rtl/ps2_key_decoder.sv | 75 +++++++
 tb/tb_ps2_key_decoder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 arrow-key path: key mask encodings (also used by car_ctl),
// scan code set 2 bytes, and the state encodings of the receiver and decoder FSMs.
package ps2_pkg;

    localparam int KEY_UP_BIT    = 0;
    localparam int KEY_DOWN_BIT  = 1;
    localparam int KEY_LEFT_BIT  = 2;
    localparam int KEY_RIGHT_BIT = 3;

    localparam logic [3:0] KEY_UP    = 4'b0001;
    localparam logic [3:0] KEY_DOWN  = 4'b0010;
    localparam logic [3:0] KEY_LEFT  = 4'b0100;
    localparam logic [3:0] KEY_RIGHT = 4'b1000;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_E0, D_E0F0, D_F0} dec_state_t;

    // Mask bit for an extended arrow scan code; zero for anything else.
    function automatic logic [3:0] key_mask(input logic [7:0] sc);
        logic [3:0] m;
        m = 4'b0000;
        case (sc)
            SC_UP:    m[KEY_UP_BIT]    = 1'b1;
            SC_DOWN:  m[KEY_DOWN_BIT]  = 1'b1;
            SC_LEFT:  m[KEY_LEFT_BIT]  = 1'b1;
            SC_RIGHT: m[KEY_RIGHT_BIT] = 1'b1;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pins in, decoded key mask and raw byte stream out.
// master drives the connector pins; slave is the decoder.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    modport master (output ps2_clk, ps2_data, input key, rx_byte, rx_valid, frame_err);
    modport slave  (input ps2_clk, ps2_data, output key, rx_byte, rx_valid, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin sync, clock glitch filter, 11-bit frame FSM with inactivity timeout.
// rx_valid/frame_err pulse one cycle after the stop-bit edge; no backpressure, bytes are fire-and-forget.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 130000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);
    localparam int              FLT_W   = $clog2(FILTER_LEN + 1);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
    localparam logic [17:0]     TO_LIM  = 18'(TIMEOUT_CYCLES);

    logic             clk_s1, clk_s2, dat_s1, dat_s2, clk_f;
    logic [FLT_W-1:0] flt_cnt;
    logic [17:0]      to_cnt;
    logic             fall;

    rx_state_t  state, state_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic [7:0] shift, shift_nxt, byte_nxt;
    logic       par_bit, par_nxt, vld_nxt, err_nxt;

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample; a falling flip is the bit strobe.
    assign fall = (clk_s2 != clk_f) && (flt_cnt == FLT_MAX) && !clk_s2;

    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            clk_f     <= 1'b1;
            flt_cnt   <= '0;
            to_cnt    <= '0;
            state     <= RX_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_MAX) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
            if (state == RX_IDLE || fall)
                to_cnt <= '0;
            else if (to_cnt != '1)
                to_cnt <= to_cnt + 1'b1;
            state     <= state_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            par_bit   <= par_nxt;
            rx_byte   <= byte_nxt;
            rx_valid  <= vld_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        par_nxt   = par_bit;
        byte_nxt  = rx_byte;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (fall) begin
            case (state)
                RX_IDLE: begin
                    if (!dat_s2) begin
                        state_nxt = RX_DATA;
                        bit_nxt   = '0;
                    end
                end
                RX_DATA: begin
                    shift_nxt = {dat_s2, shift[7:1]};
                    if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
                    else                 bit_nxt   = bit_cnt + 3'd1;
                end
                RX_PARITY: begin
                    par_nxt   = dat_s2;
                    state_nxt = RX_STOP;
                end
                RX_STOP: begin
                    if (dat_s2 && (^{shift, par_bit})) begin
                        byte_nxt = shift;
                        vld_nxt  = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = RX_IDLE;
                    bit_nxt   = '0;
                end
                default: state_nxt = RX_IDLE;
            endcase
        end else if (state != RX_IDLE && to_cnt >= TO_LIM) begin
            state_nxt = RX_IDLE;
            bit_nxt   = '0;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives scan code set 2 bytes and holds the arrow-key mask.
// key follows a byte two cycles after its stop-bit edge; no backpressure.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 130000
) (
    input  logic             pclk,
    input  logic             rst,
    ps2_key_decoder_if.slave bus
);
    logic [7:0] rx_byte;
    logic       rx_valid, frame_err;
    logic [3:0] key_q, key_nxt;
    dec_state_t dstate, d_nxt;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .pclk      (pclk),
        .rst       (rst),
        .ps2_clk   (bus.ps2_clk),
        .ps2_data  (bus.ps2_data),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    assign bus.key       = key_q;
    assign bus.rx_byte   = rx_byte;
    assign bus.rx_valid  = rx_valid;
    assign bus.frame_err = frame_err;

    always_ff @(posedge pclk) begin
        if (rst) begin
            dstate <= D_IDLE;
            key_q  <= '0;
        end else begin
            dstate <= d_nxt;
            key_q  <= key_nxt;
        end
    end

    // A corrupted byte may have been a prefix, so the sequence restarts from scratch.
    always_comb begin
        d_nxt   = dstate;
        key_nxt = key_q;
        if (frame_err) begin
            d_nxt = D_IDLE;
        end else if (rx_valid) begin
            case (dstate)
                D_IDLE: begin
                    if (rx_byte == SC_EXT)      d_nxt = D_E0;
                    else if (rx_byte == SC_BRK) d_nxt = D_F0;
                end
                D_E0: begin
                    if (rx_byte == SC_BRK) begin
                        d_nxt = D_E0F0;
                    end else begin
                        key_nxt = key_q | key_mask(rx_byte);
                        d_nxt   = D_IDLE;
                    end
                end
                D_E0F0: begin
                    key_nxt = key_q & ~key_mask(rx_byte);
                    d_nxt   = D_IDLE;
                end
                default: d_nxt = D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench: bit-bangs PS/2 frames and checks key, rx_byte and pulse counts.
module tb_ps2_key_decoder;
    logic pclk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   rv_cnt = 0;
    int   fe_cnt = 0;
    int   both_cnt = 0;

    always #5 pclk = ~pclk;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always @(negedge pclk) begin
        if (bus.rx_valid) rv_cnt++;
        if (bus.frame_err) fe_cnt++;
        if (bus.rx_valid && bus.frame_err) both_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required completion within 1ms");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // Bit cell: data changes mid-high, clock low for 20 cycles, 40 cycles per bit.
    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        wait_cyc(10);
        bus.ps2_clk = 1'b0;
        wait_cyc(20);
        bus.ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic bad_par = 1'b0);
        logic [10:0] f;
        f = mk_frame(d, bad_par);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cyc(5);
        tests++;
        if (bus.key !== 4'b0000) begin fails++; $display("FAIL reset_key got=%b exp=0000", bus.key); end
        tests++;
        if (bus.rx_byte !== 8'h00) begin fails++; $display("FAIL reset_rx_byte got=%h exp=00", bus.rx_byte); end
        tests++;
        if (bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            fails++; $display("FAIL reset_pulses got=%b%b exp=00", bus.rx_valid, bus.frame_err);
        end
        rst = 1'b0;
        wait_cyc(10000);
        tests++;
        if (bus.key !== 4'b0000) begin fails++; $display("FAIL idle_key got=%b exp=0000", bus.key); end
        tests++;
        if (rv_cnt != 0 || fe_cnt != 0) begin fails++; $display("FAIL idle_pulses rv=%0d fe=%0d exp=0,0", rv_cnt, fe_cnt); end
    endtask

    task automatic test_up_press_release;
        logic [10:0] f;
        bit found;
        send_frame(8'hE0);
        f = mk_frame(8'h75, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        bus.ps2_data = 1'b1;
        wait_cyc(10);
        bus.ps2_clk = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge pclk);
            if (bus.rx_valid) found = 1;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL up_rx_valid got=none exp=pulse within 40 cycles"); end
        tests++;
        if (bus.key !== 4'b0000) begin fails++; $display("FAIL up_key_at_valid got=%b exp=0000", bus.key); end
        tests++;
        if (bus.rx_byte !== 8'h75) begin fails++; $display("FAIL up_rx_byte got=%h exp=75", bus.rx_byte); end
        @(negedge pclk);
        tests++;
        if (bus.key !== 4'b0001) begin fails++; $display("FAIL up_key_after got=%b exp=0001", bus.key); end
        wait_cyc(10);
        bus.ps2_clk = 1'b1;
        wait_cyc(10);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
        tests++;
        if (bus.key !== 4'b0000) begin fails++; $display("FAIL up_release got=%b exp=0000", bus.key); end
    endtask

    task automatic test_multi_key;
        send_frame(8'hE0); send_frame(8'h6B);
        send_frame(8'hE0); send_frame(8'h74);
        tests++;
        if (bus.key !== 4'b1100) begin fails++; $display("FAIL multi_press got=%b exp=1100", bus.key); end
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
        tests++;
        if (bus.key !== 4'b1000) begin fails++; $display("FAIL multi_left_release got=%b exp=1000", bus.key); end
        send_frame(8'hE0); send_frame(8'h74);
        tests++;
        if (bus.key !== 4'b1000) begin fails++; $display("FAIL typematic got=%b exp=1000", bus.key); end
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h74);
        tests++;
        if (bus.key !== 4'b0000) begin fails++; $display("FAIL right_release got=%b exp=0000", bus.key); end
    endtask

    task automatic test_frame_err;
        int rv0, fe0;
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        send_frame(8'hE0);
        send_frame(8'h75, 1'b1);
        tests++;
        if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL err_pulse got=%0d exp=1", fe_cnt - fe0); end
        tests++;
        if (rv_cnt - rv0 != 1) begin fails++; $display("FAIL err_rv_count got=%0d exp=1", rv_cnt - rv0); end
        tests++;
        if (bus.rx_byte !== 8'hE0) begin fails++; $display("FAIL err_rx_byte got=%h exp=E0", bus.rx_byte); end
        tests++;
        if (bus.key !== 4'b0000) begin fails++; $display("FAIL err_key got=%b exp=0000", bus.key); end
        send_frame(8'h75);
        tests++;
        if (bus.key !== 4'b0000) begin fails++; $display("FAIL err_then_75 got=%b exp=0000", bus.key); end
        tests++;
        if (bus.rx_byte !== 8'h75) begin fails++; $display("FAIL err_then_75_byte got=%h exp=75", bus.rx_byte); end
    endtask

    task automatic test_timeout;
        logic [10:0] f;
        int rv0, fe0;
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        f = mk_frame(8'h72, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        wait_cyc(2010);
        tests++;
        if (rv_cnt != rv0 || fe_cnt != fe0) begin
            fails++; $display("FAIL timeout_pulses rv=%0d fe=%0d exp=0,0", rv_cnt - rv0, fe_cnt - fe0);
        end
        send_frame(8'hE0); send_frame(8'h72);
        tests++;
        if (bus.key !== 4'b0010) begin fails++; $display("FAIL timeout_then_down got=%b exp=0010", bus.key); end
        tests++;
        if (fe_cnt != fe0) begin fails++; $display("FAIL timeout_err got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task automatic test_non_extended;
        send_frame(8'h75);
        send_frame(8'hF0); send_frame(8'h75);
        tests++;
        if (bus.key !== 4'b0010) begin fails++; $display("FAIL keypad8 got=%b exp=0010", bus.key); end
        send_frame(8'hAA); send_frame(8'hFA);
        tests++;
        if (bus.key !== 4'b0010 || bus.rx_byte !== 8'hFA) begin
            fails++; $display("FAIL ignored_bytes got=%b/%h exp=0010/FA", bus.key, bus.rx_byte);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] f;
        int rv0, fe0;
        f = mk_frame(8'hE0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        bus.ps2_data = f[4];
        wait_cyc(10);
        bus.ps2_clk = 1'b0;
        wait_cyc(12);
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        rst = 1'b1;
        @(negedge pclk);
        tests++;
        if (bus.key !== 4'b0000) begin fails++; $display("FAIL midrst_key got=%b exp=0000", bus.key); end
        tests++;
        if (bus.rx_byte !== 8'h00) begin fails++; $display("FAIL midrst_byte got=%h exp=00", bus.rx_byte); end
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(30);
        rst = 1'b0;
        wait_cyc(500);
        tests++;
        if (rv_cnt != rv0 || fe_cnt != fe0) begin
            fails++; $display("FAIL midrst_pulses rv=%0d fe=%0d exp=0,0", rv_cnt - rv0, fe_cnt - fe0);
        end
        send_frame(8'hE0); send_frame(8'h6B);
        tests++;
        if (bus.key !== 4'b0100) begin fails++; $display("FAIL after_rst_left got=%b exp=0100", bus.key); end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        test_reset();
        test_up_press_release();
        test_multi_key();
        test_frame_err();
        test_timeout();
        test_non_extended();
        test_reset_mid_frame();
        tests++;
        if (both_cnt != 0) begin fails++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
